fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have ports imem_req output 1 and imem_addr output 32: fetch request and word address.
REQ-006 SHALL have port imem_gnt, input, 1, request accepted when imem_req && imem_gnt.
REQ-007 SHALL have ports imem_rvalid input 1 and imem_rdata input 32: response, 1+ cycles after grant.
REQ-008 SHALL have ports instr_valid output 1, instr output 32, instr_pc output 32: instruction toward the decoder.
REQ-009 SHALL have port instr_ready, input, 1, decoder consumes when instr_valid && instr_ready.
REQ-010 SHALL have ports pc_src input 1 and branch_addr input 32: taken-branch redirect.
REQ-011 SHALL have ports jmp input 1 and jmp_addr input 32: jump redirect.

Function
REQ-012 SHALL hold fetch_pc; +4 on each grant, wrapping 32'hFFFF_FFFC -> 0.
REQ-013 SHALL allow at most one outstanding request.
REQ-014 SHALL assert imem_req only in IDLE with buffer count < BUF_DEPTH; imem_addr = fetch_pc.
REQ-015 SHALL use states IDLE, WAIT, DISCARD; IDLE->WAIT on grant; WAIT->IDLE on rvalid.
REQ-016 SHALL push {imem_rdata, request address} into the buffer on rvalid in WAIT; rvalid in IDLE ignored.
REQ-017 SHALL present buffer head on instr/instr_pc, instr_valid = count != 0, pop on handshake.
REQ-018 SHALL keep count unchanged on simultaneous push and pop, including when full.
REQ-019 SHALL redirect on jmp or pc_src: flush buffer, fetch_pc <= jmp ? jmp_addr : branch_addr (jmp wins).
REQ-020 SHALL, on redirect in WAIT without same-cycle rvalid, go to DISCARD; the next rvalid is dropped, then IDLE.
REQ-021 SHALL give redirect priority over push, pop and grant in the same cycle; no request issued that cycle.
REQ-022 SHALL drive instr_valid low the cycle after a redirect; first redirected instruction valid no earlier than 2 cycles after redirect with 1-cycle memory.
REQ-023 SHALL be latency: grant at cycle N, rvalid N+1, instr_valid at N+2.

Reset
REQ-024 SHALL, on rst_n low, immediately set state IDLE, fetch_pc = RESET_PC, count 0, instr_valid 0, imem_req 0.
REQ-025 SHALL hold imem_req low during the first cycle after reset release; instr/instr_pc = 0 at reset.
REQ-026 SHALL drop any response for a request outstanding when reset asserted.

Configuration
REQ-027 SHALL, with FETCH_PERF_EN defined, add outputs fetch_cnt 32 (grants) and flush_cnt 32 (redirects), reset 0, wrapping.
REQ-028 SHALL, without FETCH_PERF_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-029 SHALL place addr_t/word_t (32-bit) and fetch_state_t enum in package lib_cpu.
REQ-030 SHALL implement the buffer as sub-module fetch_buf (synchronous FIFO with flush, push, pop, count).

Verification
REQ-031 Reset release, gnt=1, 1-cycle memory, ready=1 -> addresses 0,4,8 issued; instr_pc 0,4,8 back-to-back.
REQ-032 ready=0 with gnt=1 -> exactly BUF_DEPTH (2) instructions buffered, imem_req low, no loss after ready=1.
REQ-033 pc_src=1, branch_addr=32'h40 while WAIT -> in-flight word dropped, next instr_pc = 32'h40.
REQ-034 jmp=1 jmp_addr=32'h100 and pc_src=1 branch_addr=32'h80 same cycle -> next instr_pc = 32'h100.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 rst_n low mid-WAIT, then release -> instr_valid 0, refetch from RESET_PC; with FETCH_PERF_EN fetch_cnt restarts at 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types: address/word aliases, FSM states, buffer entry.
// Used by fetch_unit and fetch_buf.
package lib_cpu;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    addr_t pc;
  } fetch_ent_t;

  localparam addr_t PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: synchronous FIFO with flush, push, pop and count.
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_buf
  import lib_cpu::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_ent_t               wdata,
  output fetch_ent_t               rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_ent_t     mem_q [DEPTH];
  fetch_ent_t     mem_d [DEPTH];
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [AW:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = wdata;
        wp_d        = wp_q + AW'(1);
      end
      if (pop) rp_d = rp_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one-outstanding imem requester feeding a small instr buffer.
// Optional FETCH_PERF_EN adds grant/redirect counters (fetch_cnt, flush_cnt).
module fetch_unit
  import lib_cpu::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        pc_src,
  input  logic [31:0] branch_addr,
  input  logic        jmp,
  input  logic [31:0] jmp_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  fetch_state_t   state_q, state_d;
  addr_t          pc_q, pc_d;
  addr_t          req_pc_q, req_pc_d;
  logic           live_q;
  logic [CW-1:0]  count;
  fetch_ent_t     head;
  logic           redirect, grant, push, pop;

  assign redirect  = jmp | pc_src;
  // live_q keeps the first cycle out of reset request-free
  assign imem_req  = live_q && (state_q == IDLE) &&
                     (count < FULL) && !redirect;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;
  assign push      = (state_q == WAIT) && imem_rvalid && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect) begin
      pc_d    = jmp ? jmp_addr : branch_addr;
      state_d = (state_q != IDLE && !imem_rvalid) ? DISCARD : IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (grant) begin
          state_d  = WAIT;
          req_pc_d = pc_q;
          pc_d     = pc_q + PC_STEP;
        end
        WAIT:    if (imem_rvalid) state_d = IDLE;
        DISCARD: if (imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      live_q   <= 1'b1;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ('{instr: imem_rdata, pc: req_pc_q}),
    .rdata (head),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fcnt_q, fcnt_d;
  logic [31:0] flcnt_q, flcnt_d;

  always_comb begin
    fcnt_d  = fcnt_q + {31'd0, grant};
    flcnt_d = flcnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q  <= '0;
      flcnt_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      flcnt_q <= flcnt_d;
    end
  end

  assign fetch_cnt = fcnt_q;
  assign flush_cnt = flcnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a stream-level fetch model.
// Second instance checks address wrap from a high RESET_PC.
module tb_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        pc_src, jmp;
  logic [31:0] branch_addr, jmp_addr;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt, flush_cnt;
  logic [31:0] w_fcnt, w_flcnt;
`endif

  logic        w_req, w_rvalid, w_ivalid;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .pc_src(pc_src), .branch_addr(branch_addr),
    .jmp(jmp), .jmp_addr(jmp_addr)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(1'b1), .imem_rvalid(w_rvalid),
    .imem_rdata(32'h0000_0013),
    .instr_valid(w_ivalid), .instr(w_instr),
    .instr_pc(w_pc), .instr_ready(1'b1),
    .pc_src(1'b0), .branch_addr(32'h0),
    .jmp(1'b0), .jmp_addr(32'h0)
`ifdef FETCH_PERF_EN
    , .fetch_cnt(w_fcnt), .flush_cnt(w_flcnt)
`endif
  );

  // 1-cycle memory for the wrap instance
  always @(posedge clk or negedge rst_n)
    if (!rst_n) w_rvalid <= 1'b0;
    else        w_rvalid <= w_req;

  always @(negedge clk)
    if (rst_n && w_req && wq.size() < 3) wq.push_back(w_addr);

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  int          occ;
  logic [31:0] exp_fetch, exp_pc;
  bit          pend, stale, first, spur;
  int          lat, fixed_lat;
  logic [31:0] pend_addr, last_cons;
  int          n_cons;
  logic [31:0] gq[$];
  logic [31:0] exp_fcnt, exp_flcnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    pc_src = 1'b0; jmp = 1'b0;
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_instr", instr,            32'd0);
    chk("rst_pc",    instr_pc,         32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    occ = 0; pend = 0; stale = 0; first = 1; spur = 1;
    exp_fetch = RPC; exp_pc = RPC;
    gq.delete();
    exp_fcnt = 0; exp_flcnt = 0;
  endtask

  task automatic cycle(input bit g, input bit r, input bit j,
                       input logic [31:0] ja, input bit b,
                       input logic [31:0] ba);
    bit resp, redir, ereq, cons, gr;
    @(negedge clk);
    imem_gnt = g; instr_ready = r;
    jmp = j; jmp_addr = ja; pc_src = b; branch_addr = ba;
    resp = pend && (lat == 1);
    if (resp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr);
    end else begin
      imem_rvalid = !pend && (spur || $urandom_range(7) == 0);
      imem_rdata  = $urandom;
    end
    spur = 0;
    #2;
    redir = j | b;
    ereq = !first && !pend && (occ < DEPTH) && !redir;
    chk("req", 32'(imem_req), 32'(ereq));
    if (ereq) chk("addr", imem_addr, exp_fetch);
    chk("valid", 32'(instr_valid), 32'(occ != 0));
    if (occ != 0) begin
      chk("pc", instr_pc, exp_pc);
      chk("instr", instr, mem_word(exp_pc));
    end
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, exp_fcnt);
    chk("flush_cnt", flush_cnt, exp_flcnt);
`endif
    cons = (occ != 0) && r && !redir;
    gr   = ereq && g;
    if (cons) begin
      occ--; last_cons = exp_pc; n_cons++; exp_pc += 4;
    end
    if (resp) begin
      pend = 0;
      if (!stale && !redir) occ++;
    end else if (pend) begin
      lat--;
      if (redir) stale = 1;
    end
    if (gr) begin
      pend = 1; stale = 0; pend_addr = exp_fetch;
      lat = fixed_lat != 0 ? fixed_lat : int'($urandom_range(3, 1));
      gq.push_back(exp_fetch);
      exp_fetch += 4; exp_fcnt++;
    end
    if (redir) begin
      occ = 0;
      exp_fetch = j ? ja : ba;
      exp_pc = exp_fetch;
      exp_flcnt++;
    end
    first = 0;
  endtask

  task automatic wait_wait_state();
    int k;
    for (k = 0; k < 20; k++) begin
      if (pend && lat >= 2) break;
      cycle(1, 1, 0, 0, 0, 0);
    end
    if (k == 20) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cons(input string tag, input logic [31:0] exp);
    int k, n0;
    n0 = n_cons;
    for (k = 0; k < 30 && n_cons == n0; k++) cycle(1, 1, 0, 0, 0, 0);
    if (n_cons == n0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else              chk(tag, last_cons, exp);
  endtask

  initial begin
    logic [31:0] ja, ba;
    bit j, b;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
    pc_src = 0; jmp = 0; branch_addr = 0; jmp_addr = 0;
    n_cons = 0; last_cons = 0;

    // straight-line fetch, 1-cycle memory
    fixed_lat = 1;
    do_reset();
    repeat (12) cycle(1, 1, 0, 0, 0, 0);
    if (gq.size() >= 3) begin
      chk("seq_a0", gq[0], 32'h0);
      chk("seq_a1", gq[1], 32'h4);
      chk("seq_a2", gq[2], 32'h8);
    end else chk("seq_grants", gq.size(), 3);
    if (wq.size() == 3) begin
      chk("wrap_a0", wq[0], 32'hFFFF_FFF8);
      chk("wrap_a1", wq[1], 32'hFFFF_FFFC);
      chk("wrap_a2", wq[2], 32'h0000_0000);
    end else chk("wrap_grants", wq.size(), 3);

    // decoder stalled: buffer fills, requests stop
    repeat (12) cycle(1, 0, 0, 0, 0, 0);
    chk("full_occ", occ, DEPTH);
    chk("full_req", 32'(imem_req), 32'd0);
    repeat (12) cycle(1, 1, 0, 0, 0, 0);

    // branch while a response is in flight
    fixed_lat = 2;
    wait_wait_state();
    cycle(1, 1, 0, 0, 1, 32'h40);
    wait_cons("br_target", 32'h40);

    // jump beats branch in the same cycle
    wait_wait_state();
    cycle(1, 1, 1, 32'h100, 1, 32'h80);
    wait_cons("jmp_prio", 32'h100);

    // reset with a request outstanding
    fixed_lat = 3;
    wait_wait_state();
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    chk("rst_mid_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 10 && gq.size() == 0; k++)
      cycle(1, 1, 0, 0, 0, 0);
    if (gq.size() > 0) chk("refetch", gq[0], RPC);
    else chk("refetch_timeout", 32'd0, 32'd1);

    // random traffic
    fixed_lat = 0;
    for (int i = 0; i < 3000; i++) begin
      j  = ($urandom_range(29) == 0);
      b  = ($urandom_range(19) == 0);
      ja = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      ba = $urandom & 32'hFFFF_FFFC;
      cycle($urandom_range(3) != 0, $urandom_range(2) != 0, j, ja, b, ba);
      if (i == 1500) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
